// File: rtl/max_pool_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : max_pool_sequencer
//  Description : Reduces each window of CFG_WIN unsigned samples to its
//                maximum and presents one result per window on a
//                valid/ready output. Ties keep the earliest sample.
//                Optional argmax output enabled by MAXPOOL_ARGMAX_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module max_pool_sequencer #(
    parameter int DATA_WIDTH = 16,
    parameter int POOL_SIZE  = 4,
    localparam int CNT_W     = $clog2(POOL_SIZE + 1)
) (
    input  logic                  CLK,
    input  logic                  RESET_N,
    input  logic [CNT_W-1:0]      CFG_WIN,
    input  logic                  IN_VALID,
    output logic                  IN_READY,
    input  logic [DATA_WIDTH-1:0] IN_DATA,
    output logic                  OUT_VALID,
    input  logic                  OUT_READY,
    output logic [DATA_WIDTH-1:0] OUT_DATA,
`ifdef MAXPOOL_ARGMAX_EN
    output logic [CNT_W-1:0]      OUT_IDX,
`endif
    output logic                  BUSY
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] C_POOL_MAX = CNT_W'(POOL_SIZE);
    localparam logic [CNT_W-1:0] C_ONE      = CNT_W'(1);

    state_t                  state_q,     state_d;
    logic [DATA_WIDTH-1:0]   max_q,       max_d;
    logic [CNT_W-1:0]        count_q,     count_d;
    logic [CNT_W-1:0]        win_q,       win_d;
    logic                    out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0]   out_data_q,  out_data_d;
    logic                    busy_q,      busy_d;
`ifdef MAXPOOL_ARGMAX_EN
    logic [CNT_W-1:0]        idx_q,       idx_d;
    logic [CNT_W-1:0]        out_idx_q,   out_idx_d;
    logic [CNT_W-1:0]        new_idx;
`endif

    logic                    in_fire;
    logic [CNT_W-1:0]        win_eff;
    logic [CNT_W-1:0]        count_inc;
    logic [DATA_WIDTH-1:0]   new_max;

    // Input readiness depends on state only, never on OUT_READY
    assign IN_READY  = (state_q != ST_HOLD);
    assign in_fire   = IN_VALID && IN_READY;
    assign count_inc = count_q + C_ONE;

    // Effective window: zero means one sample, oversize clamps to POOL_SIZE
    always_comb begin
        if (CFG_WIN == '0) begin
            win_eff = C_ONE;
        end else if (CFG_WIN > C_POOL_MAX) begin
            win_eff = C_POOL_MAX;
        end else begin
            win_eff = CFG_WIN;
        end
    end

    // Running maximum with strict compare so ties keep the first sample
    always_comb begin
        new_max = max_q;
`ifdef MAXPOOL_ARGMAX_EN
        new_idx = idx_q;
`endif
        if (IN_DATA > max_q) begin
            new_max = IN_DATA;
`ifdef MAXPOOL_ARGMAX_EN
            new_idx = count_q;
`endif
        end
    end

    // Next-state and registered-output computation
    always_comb begin
        state_d     = state_q;
        max_d       = max_q;
        count_d     = count_q;
        win_d       = win_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        busy_d      = busy_q;
`ifdef MAXPOOL_ARGMAX_EN
        idx_d       = idx_q;
        out_idx_d   = out_idx_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (in_fire) begin
                    max_d   = IN_DATA;
                    count_d = C_ONE;
                    win_d   = win_eff;
                    busy_d  = 1'b1;
`ifdef MAXPOOL_ARGMAX_EN
                    idx_d   = '0;
`endif
                    if (win_eff == C_ONE) begin
                        state_d     = ST_HOLD;
                        out_valid_d = 1'b1;
                        out_data_d  = IN_DATA;
`ifdef MAXPOOL_ARGMAX_EN
                        out_idx_d   = '0;
`endif
                    end else begin
                        state_d = ST_ACCUM;
                    end
                end
            end
            ST_ACCUM: begin
                if (in_fire) begin
                    max_d   = new_max;
                    count_d = count_inc;
`ifdef MAXPOOL_ARGMAX_EN
                    idx_d   = new_idx;
`endif
                    if (count_inc == win_q) begin
                        state_d     = ST_HOLD;
                        out_valid_d = 1'b1;
                        out_data_d  = new_max;
`ifdef MAXPOOL_ARGMAX_EN
                        out_idx_d   = new_idx;
`endif
                    end
                end
            end
            ST_HOLD: begin
                if (OUT_READY) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                    busy_d      = 1'b0;
                    count_d     = '0;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                out_valid_d = 1'b0;
                busy_d      = 1'b0;
                count_d     = '0;
            end
        endcase
    end

    // State and output registers; async reset discards any partial window
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q     <= ST_IDLE;
            max_q       <= '0;
            count_q     <= '0;
            win_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            busy_q      <= 1'b0;
`ifdef MAXPOOL_ARGMAX_EN
            idx_q       <= '0;
            out_idx_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            max_q       <= max_d;
            count_q     <= count_d;
            win_q       <= win_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            busy_q      <= busy_d;
`ifdef MAXPOOL_ARGMAX_EN
            idx_q       <= idx_d;
            out_idx_q   <= out_idx_d;
`endif
        end
    end

    assign OUT_VALID = out_valid_q;
    assign OUT_DATA  = out_data_q;
    assign BUSY      = busy_q;
`ifdef MAXPOOL_ARGMAX_EN
    assign OUT_IDX   = out_idx_q;
`endif

endmodule
`default_nettype wire
